// File: rtl/bit_serial_adder_if.sv
// bit_serial_adder_if: operand and result handshakes of the bit-serial adder
//   master: drives in_valid, a, b, cin, out_ready; observes in_ready, out_valid, sum, cout, busy
//   slave : the adder side of the same signals
interface bit_serial_adder_if #(parameter int WIDTH = 8);
  logic in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
  logic [WIDTH-1:0] a, b, sum;
  modport master (output in_valid, a, b, cin, out_ready, input in_ready, out_valid, sum, cout, busy);
  modport slave (input in_valid, a, b, cin, out_ready, output in_ready, out_valid, sum, cout, busy);
endinterface

// File: rtl/bit_serial_adder.sv
// bit_serial_adder: WIDTH-bit adder that drives one full-adder cell per clock, LSB first
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of bit_serial_adder_if (operands in, sum/cout out, busy)
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  bit_serial_adder_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] a_sr_q, b_sr_q, sum_sr_q;
  logic [CW-1:0]    cnt_q;
  logic             c_q, out_valid_q, s_d, c_d;
  assign s_d = a_sr_q[0] ^ b_sr_q[0] ^ c_q;
  assign c_d = (a_sr_q[0] & b_sr_q[0]) | (c_q & (a_sr_q[0] ^ b_sr_q[0]));
  // in_ready is a pure state decode so it reads 1 while reset is held
  assign bus.in_ready  = state_q == IDLE;
  assign bus.busy      = state_q != IDLE;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_sr_q;
  assign bus.cout      = c_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      sum_sr_q    <= '0;
      c_q         <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          a_sr_q  <= bus.a;
          b_sr_q  <= bus.b;
          c_q     <= bus.cin;
          cnt_q   <= '0;
          state_q <= RUN;
        end
        RUN: begin
          // sum bits enter at the MSB so after WIDTH shifts bit 0 sits at sum_sr_q[0]
          sum_sr_q <= {s_d, sum_sr_q[WIDTH-1:1]};
          a_sr_q   <= a_sr_q >> 1;
          b_sr_q   <= b_sr_q >> 1;
          c_q      <= c_d;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: if (bus.out_ready) begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bit_serial_adder.sv
// tb_bit_serial_adder: directed self-checking bench for bit_serial_adder at WIDTH 8, 3 and 2
module tb_bit_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  bit_serial_adder_if #(.WIDTH(8)) if8();
  bit_serial_adder_if #(.WIDTH(3)) if3();
  bit_serial_adder_if #(.WIDTH(2)) if2();
  bit_serial_adder #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  bit_serial_adder #(.WIDTH(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));
  bit_serial_adder #(.WIDTH(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin, output int lat);
    @(negedge clk);
    if8.a = a;
    if8.b = b;
    if8.cin = cin;
    if8.in_valid = 1'b1;
    @(negedge clk);
    if8.in_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (if8.out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic consume8;
    if8.out_ready = 1'b1;
    @(negedge clk);
    if8.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({if8.in_ready, if8.out_valid, if8.sum, if8.cout, if8.busy} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got rdy=%b ov=%b sum=%h cout=%b busy=%b want 1 0 00 0 0",
               if8.in_ready, if8.out_valid, if8.sum, if8.cout, if8.busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int lat;
    op8(8'hFF, 8'h01, 1'b0, lat);
    checks++;
    if (lat !== 8) begin errors++; $display("FAIL basic_latency got %0d want 8", lat); end
    checks++;
    if ({if8.cout, if8.sum} !== 9'h100) begin errors++; $display("FAIL basic_sum got %b_%h want 1_00", if8.cout, if8.sum); end
    checks++;
    if ({if8.busy, if8.in_ready} !== 2'b10) begin errors++; $display("FAIL basic_done_flags got busy=%b rdy=%b want 1 0", if8.busy, if8.in_ready); end
    consume8();
    checks++;
    if ({if8.out_valid, if8.in_ready, if8.busy} !== 3'b010) begin
      errors++;
      $display("FAIL basic_drain got ov=%b rdy=%b busy=%b want 0 1 0", if8.out_valid, if8.in_ready, if8.busy);
    end
  endtask

  task automatic test_vectors;
    int lat;
    op8(8'h5A, 8'hA5, 1'b1, lat);
    checks++;
    if ({lat == 8, if8.cout, if8.sum} !== 10'b11_0000_0000) begin
      errors++;
      $display("FAIL vec_5a_a5 got lat=%0d %b_%h want lat=8 1_00", lat, if8.cout, if8.sum);
    end
    consume8();
    op8(8'h12, 8'h34, 1'b0, lat);
    checks++;
    if ({lat == 8, if8.cout, if8.sum} !== {1'b1, 1'b0, 8'h46}) begin
      errors++;
      $display("FAIL vec_12_34 got lat=%0d %b_%h want lat=8 0_46", lat, if8.cout, if8.sum);
    end
    consume8();
  endtask

  task automatic test_backpressure;
    int lat;
    op8(8'h81, 8'h02, 1'b1, lat);
    for (int k = 0; k < 5; k++) begin
      if8.a = 8'hFF;
      if8.b = 8'hFF;
      if8.cin = 1'b1;
      if8.in_valid = ~k[0];
      @(negedge clk);
      checks++;
      if ({if8.out_valid, if8.in_ready, if8.cout, if8.sum} !== {1'b1, 1'b0, 1'b0, 8'h84}) begin
        errors++;
        $display("FAIL hold_cycle%0d got ov=%b rdy=%b %b_%h want 1 0 0_84", k, if8.out_valid, if8.in_ready, if8.cout, if8.sum);
      end
    end
    if8.in_valid = 1'b0;
    consume8();
    @(negedge clk);
    checks++;
    if ({if8.busy, if8.out_valid, if8.cout, if8.sum} !== {1'b0, 1'b0, 1'b0, 8'h84}) begin
      errors++;
      $display("FAIL hold_no_capture got busy=%b ov=%b %b_%h want 0 0 0_84", if8.busy, if8.out_valid, if8.cout, if8.sum);
    end
  endtask

  task automatic test_reset_midrun;
    int lat;
    bit seen;
    @(negedge clk);
    if8.a = 8'hC3;
    if8.b = 8'h3C;
    if8.cin = 1'b0;
    if8.in_valid = 1'b1;
    @(negedge clk);
    if8.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({if8.in_ready, if8.out_valid, if8.sum, if8.cout, if8.busy} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midrun_reset got rdy=%b ov=%b sum=%h cout=%b busy=%b want 1 0 00 0 0",
               if8.in_ready, if8.out_valid, if8.sum, if8.cout, if8.busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      seen |= if8.out_valid;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL midrun_aborted got out_valid=%b want 0", seen); end
    op8(8'h03, 8'h04, 1'b0, lat);
    checks++;
    if ({lat == 8, if8.cout, if8.sum} !== {1'b1, 1'b0, 8'h07}) begin
      errors++;
      $display("FAIL after_reset_op got lat=%0d %b_%h want lat=8 0_07", lat, if8.cout, if8.sum);
    end
    consume8();
  endtask

  task automatic test_back_to_back;
    int prev = 0;
    int acc;
    logic [6:0] v;
    logic [3:0] exp;
    if3.out_ready = 1'b1;
    for (int i = 0; i < 128; i++) begin
      v = 7'(i);
      for (int w = 0; w < 20 && !if3.in_ready; w++) @(negedge clk);
      checks++;
      if (if3.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_timeout op%0d got %b want 1", i, if3.in_ready); end
      if3.a = v[6:4];
      if3.b = v[3:1];
      if3.cin = v[0];
      if3.in_valid = 1'b1;
      acc = cyc;
      if (i > 0) begin
        checks++;
        if (acc - prev !== 5) begin errors++; $display("FAIL b2b_spacing op%0d got %0d want 5", i, acc - prev); end
      end
      prev = acc;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (if3.out_valid) break;
      end
      exp = 4'(v[6:4]) + 4'(v[3:1]) + 4'(v[0]);
      checks++;
      if ({if3.out_valid, if3.cout, if3.sum} !== {1'b1, exp}) begin
        errors++;
        $display("FAIL b2b_sum a=%0d b=%0d cin=%0d got ov=%b %b_%b want 1 %b", v[6:4], v[3:1], v[0], if3.out_valid, if3.cout, if3.sum, exp);
      end
    end
    if3.in_valid = 1'b0;
    @(negedge clk);
    if3.out_ready = 1'b0;
  endtask

  task automatic test_width2;
    int lat = 0;
    @(negedge clk);
    if2.a = 2'b11;
    if2.b = 2'b11;
    if2.cin = 1'b1;
    if2.in_valid = 1'b1;
    @(negedge clk);
    if2.in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (if2.out_valid) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL w2_latency got %0d want 2", lat); end
    checks++;
    if ({if2.cout, if2.sum} !== 3'b111) begin errors++; $display("FAIL w2_sum got %b_%b want 1_11", if2.cout, if2.sum); end
  endtask

  initial begin
    {if8.in_valid, if8.a, if8.b, if8.cin, if8.out_ready} = '0;
    {if3.in_valid, if3.a, if3.b, if3.cin, if3.out_ready} = '0;
    {if2.in_valid, if2.a, if2.b, if2.cin, if2.out_ready} = '0;
    test_reset();
    test_basic();
    test_vectors();
    test_backpressure();
    test_reset_midrun();
    test_back_to_back();
    test_width2();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
